// File: rtl/uart_rx_pkg.sv
// Shared definitions for the APB UART receiver: register map, STATUS/CTRL bit
// positions and receiver FSM states.
package uart_rx_pkg;

    localparam logic [4:0] ADDR_DATA   = 5'h00;
    localparam logic [4:0] ADDR_STATUS = 5'h04;
    localparam logic [4:0] ADDR_CTRL   = 5'h08;
    localparam logic [4:0] ADDR_BAUD   = 5'h0C;
    localparam logic [4:0] ADDR_THRESH = 5'h10;

    localparam int ST_RXRDY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_PERR    = 2;
    localparam int ST_FERR    = 3;
    localparam int ST_OVF     = 4;
    localparam int ST_BRK     = 5;
    localparam int ST_LVL_LSB = 8;

    localparam int CT_EN    = 0;
    localparam int CT_PEN   = 1;
    localparam int CT_ODD   = 2;
    localparam int CT_IE    = 3;
    localparam int CT_FLUSH = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: power-of-two ring buffer with level count, same-cycle push/pop
// and a one-cycle flush. level_nxt exposes the post-edge level for registered flags.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [$clog2(FIFO_DEPTH):0]   level_nxt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];
    assign level_nxt = flush ? '0 : level + LW'(do_push) - LW'(do_pop);

    always_ff @(posedge clk)
        if (do_push && !flush) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo_apb.sv
// UART receiver with 16x oversampling, parity/framing/break detection, RX FIFO
// and an APB register interface with a threshold/error level interrupt.
module uart_rx_fifo_apb
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_WIDTH = 13
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [4:0]  PADDR,
    input  logic [15:0] PWDATA,
    output logic [15:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        RX,
    output logic        RXRDY,
    output logic        OVERFLOW,
    output logic        IRQ
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                  rx_s1, rx_sync;
    logic                  en, pen, odd, ie;
    logic [BAUD_WIDTH-1:0] baud_div, baud_cnt;
    logic [LW-1:0]         thresh, level, level_nxt;
    logic                  perr, ferr, ovf, brk;
    logic                  perr_nxt, ferr_nxt, ovf_nxt, brk_nxt;
    logic                  acc, wr, rd, sel_data, sel_status, sel_ctrl, sel_baud, sel_thresh, unmapped;
    logic                  push, pop, flush, full, empty;
    logic [DATA_WIDTH-1:0] head, shreg;
    logic [3:0]            clr;
    logic                  tick, smp, brk_cond, stop_smp, perr_set;
    rx_state_t             state, state_nxt;
    logic [3:0]            tick_cnt, bit_cnt;
    logic                  par_bit;
    logic                  unused_pwdata;

    assign unused_pwdata = ^PWDATA;

    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_sync <= rx_s1;
        end

    // APB decode
    assign acc        = PSEL & PENABLE;
    assign wr         = acc & PWRITE;
    assign rd         = acc & ~PWRITE;
    assign sel_data   = (PADDR == ADDR_DATA);
    assign sel_status = (PADDR == ADDR_STATUS);
    assign sel_ctrl   = (PADDR == ADDR_CTRL);
    assign sel_baud   = (PADDR == ADDR_BAUD);
    assign sel_thresh = (PADDR == ADDR_THRESH);
    assign unmapped   = ~(sel_data | sel_status | sel_ctrl | sel_baud | sel_thresh);
    assign PREADY     = 1'b1;
    assign PSLVERR    = acc & (unmapped | (~PWRITE & sel_data & empty));
    assign pop        = rd & sel_data & ~empty;
    assign flush      = wr & sel_ctrl & PWDATA[CT_FLUSH];
    assign clr        = (wr & sel_status) ? PWDATA[ST_BRK:ST_PERR] : 4'b0;

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            if (sel_data && !empty) PRDATA = 16'(head);
            if (sel_status) begin
                PRDATA[ST_RXRDY]             = ~empty;
                PRDATA[ST_FULL]              = full;
                PRDATA[ST_PERR]              = perr;
                PRDATA[ST_FERR]              = ferr;
                PRDATA[ST_OVF]               = ovf;
                PRDATA[ST_BRK]               = brk;
                PRDATA[ST_LVL_LSB +: 7]      = 7'(level);
            end
            if (sel_ctrl) PRDATA[CT_IE:CT_EN] = {ie, odd, pen, en};
            if (sel_baud)   PRDATA = 16'(baud_div);
            if (sel_thresh) PRDATA = 16'(thresh);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) begin
            {ie, odd, pen, en} <= 4'b0;
            baud_div           <= '0;
            thresh             <= LW'(1);
        end else if (wr) begin
            if (sel_ctrl)   {ie, odd, pen, en} <= PWDATA[CT_IE:CT_EN];
            if (sel_baud)   baud_div <= PWDATA[BAUD_WIDTH-1:0];
            if (sel_thresh) thresh   <= PWDATA[LW-1:0];
        end

    // Baud generator: one 16x tick every baud_div+1 cycles, parked while disabled
    assign tick = en & (baud_cnt >= baud_div);
    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN)  baud_cnt <= '0;
        else if (!en || tick) baud_cnt <= '0;
        else           baud_cnt <= baud_cnt + BAUD_WIDTH'(1);

    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) state <= S_IDLE;
        else          state <= state_nxt;

    // Start bit is checked mid-bit (8 ticks); every later sample is one bit (16 ticks) on
    always_comb begin
        state_nxt = state;
        smp = tick && (state != S_IDLE) && (tick_cnt == ((state == S_START) ? 4'd7 : 4'd15));
        case (state)
            S_IDLE:   if (!rx_sync) state_nxt = S_START;
            S_START:  if (smp) state_nxt = rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (smp && bit_cnt == 4'(DATA_WIDTH - 1)) state_nxt = pen ? S_PARITY : S_STOP;
            S_PARITY: if (smp) state_nxt = S_STOP;
            S_STOP:   if (smp) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (!en) state_nxt = S_IDLE;
    end

    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (state_nxt != state) tick_cnt <= '0;
            else if (tick)          tick_cnt <= tick_cnt + 4'd1;
            if (state == S_IDLE) begin
                bit_cnt <= '0;
                par_bit <= 1'b0;
            end
            if (smp && state == S_DATA) begin
                shreg   <= {rx_sync, shreg[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (smp && state == S_PARITY) par_bit <= rx_sync;
        end

    assign stop_smp = smp & (state == S_STOP);
    assign brk_cond = (shreg == '0) & ~par_bit;
    assign perr_set = smp & (state == S_PARITY) & (rx_sync != (^shreg ^ odd));
    assign push     = stop_smp & (rx_sync | ~brk_cond);

    // Set wins over a same-cycle software clear
    assign perr_nxt = perr_set | (perr & ~clr[0]);
    assign ferr_nxt = (stop_smp & ~rx_sync & ~brk_cond) | (ferr & ~clr[1]);
    assign ovf_nxt  = (push & full & ~pop & ~flush) | (ovf & ~clr[2]);
    assign brk_nxt  = (stop_smp & ~rx_sync & brk_cond) | (brk & ~clr[3]);

    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) begin
            {perr, ferr, ovf, brk} <= 4'b0;
            IRQ                    <= 1'b0;
        end else begin
            {perr, ferr, ovf, brk} <= {perr_nxt, ferr_nxt, ovf_nxt, brk_nxt};
            IRQ <= ie & (((level_nxt >= thresh) & (level_nxt != '0)) |
                         perr_nxt | ferr_nxt | ovf_nxt | brk_nxt);
        end

    assign RXRDY    = ~empty;
    assign OVERFLOW = ovf;

    uart_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (PCLK),
        .rst_n     (PRESETN),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     (shreg),
        .rdata     (head),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .level_nxt (level_nxt)
    );

endmodule
